// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// Reset sequencer and lock supervisor for the system PLL. It runs on the
// PLL reference clock (refclk). It pulses the PLL reset and waits for a
// synchronized lock. The design-wide reset is released only after lock has
// been continuously stable. On lock loss, or on lock timeout, the PLL is
// re-armed and the event is counted.
//
// Optional feature macro: PLL_RESET_CTRL_WATCHDOG_EN
//   defined   : WAIT_LOCK times out after LOCK_TIMEOUT_CYCLES, re-pulses the
//               PLL and bumps retry_cnt.
//   undefined : WAIT_LOCK waits forever; retry_cnt is tied to 0.
//
// Ports
//   refclk        in   block clock (50 MHz board reference)
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock, asynchronous to refclk
//   pll_rst       out  PLL reset, active high (registered)
//   sys_rst_n     out  design reset, active low, high only in RUN (registered)
//   ready         out  copy of sys_rst_n for status LED / CSR
//   lock_loss_cnt out  RUN -> lock-lost events, saturates at 255
//   retry_cnt     out  lock timeouts, saturates at 255
//   dbg_state     out  current FSM state
//                      (0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN)
//
// Handshake: none. pll_locked is a level that is sampled through a 2-flop
// synchronizer. All outputs are levels that change only on refclk rising
// edges, or asynchronously on reset assertion.

module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // The shared counter must be able to hold every terminal count.
  localparam int MAX_A      = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                              RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;

  if (longint'(MAX_CYCLES) - 1 > (longint'(1) << CNT_W) - 1) begin : g_cnt_w_check
    $error("pll_reset_ctrl: CNT_W too small for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             locked_s;

  // Two-flop synchronizer. This is the only place pll_locked is sampled.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

`ifdef PLL_RESET_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`else
  assign retry_cnt = 8'd0;
`endif

  // FSM. Outputs are registered decodes of the next state, so they change on
  // the same edge as the state register. The counter clears on every state
  // change and holds while in RUN.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RESET_PLL;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      lock_loss_cnt <= 8'd0;
`ifdef PLL_RESET_CTRL_WATCHDOG_EN
      retry_cnt     <= 8'd0;
`endif
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          // Lock wins over a timeout that lands on the same cycle.
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
`ifdef PLL_RESET_CTRL_WATCHDOG_EN
          else if (cnt == TIMEOUT_LAST) begin
            state   <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
`endif
        end

        STABLE: begin
          // Any drop of lock restarts the wait (and its timeout window).
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RUN: begin
          // No filtering on loss: a single low synchronized sample re-arms.
          if (!locked_s) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end
        end

        default: begin
          state     <= RESET_PLL;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = sys_rst_n;
  assign dbg_state = state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl. It uses RST_PULSE_CYCLES=4,
// LOCK_STABLE_CYCLES=8 and LOCK_TIMEOUT_CYCLES=32. The timeout and priority
// checks follow the build: they run when PLL_RESET_CTRL_WATCHDOG_EN is
// defined. Otherwise the bench checks that no re-pulse happens.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, or between edges for the async reset check.

module tb_pll_reset_ctrl;

  localparam logic [1:0] S_RESET_PLL = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [7:0] retry_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .CNT_W              (16)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt    (retry_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  // ---------------- driver / checker tasks ----------------
  // Advance n rising edges and land on the following falling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call on the falling edge just before the first edge that samples lock=1.
  // With LOCK_STABLE_CYCLES=8, release lands on edge 11.
  task automatic expect_release(input string tag);
    wait_edges(10);
    check_eq({tag, "_sys_rst_n_pre"}, 32'(sys_rst_n), 32'd0);
    wait_edges(1);
    check_eq({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd1);
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    check_eq({tag, "_pll_rst"}, 32'(pll_rst), 32'd0);
  endtask

  int exp_loss;
  logic seen_rst;

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    exp_loss   = 0;
    seen_rst   = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    check_eq("reset_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check_eq("reset_ready", 32'(ready), 32'd0);
    check_eq("reset_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check_eq("reset_retry_cnt", 32'(retry_cnt), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'(S_RESET_PLL));

    // ---- clean bring-up ----
    @(negedge refclk);
    rst_n = 1'b1;
    wait_edges(3);
    check_eq("bringup_pll_rst_edge3", 32'(pll_rst), 32'd1);
    wait_edges(1);
    check_eq("bringup_pll_rst_edge4", 32'(pll_rst), 32'd0);
    check_eq("bringup_state_wait", 32'(dbg_state), 32'(S_WAIT_LOCK));
    wait_edges(10);
    pll_locked = 1'b1;
    expect_release("bringup");
    check_eq("bringup_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check_eq("bringup_retry_cnt", 32'(retry_cnt), 32'd0);

    // ---- lock loss in RUN, then relock ----
    pll_locked = 1'b0;
    wait_edges(2);
    check_eq("loss_sys_rst_n_edge2", 32'(sys_rst_n), 32'd1);
    check_eq("loss_pll_rst_edge2", 32'(pll_rst), 32'd0);
    wait_edges(1);
    check_eq("loss_sys_rst_n_edge3", 32'(sys_rst_n), 32'd0);
    check_eq("loss_pll_rst_edge3", 32'(pll_rst), 32'd1);
    check_eq("loss_cnt_edge3", 32'(lock_loss_cnt), 32'd1);
    wait_edges(4);
    check_eq("loss_pll_rst_pulse_end", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    expect_release("relock");

    // ---- async reset in RUN, between edges ----
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check_eq("async_ready", 32'(ready), 32'd0);
    check_eq("async_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("async_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check_eq("async_retry_cnt", 32'(retry_cnt), 32'd0);
    pll_locked = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;

    // ---- glitch during STABLE ----
    wait_edges(4);
    check_eq("glitch_pll_rst_end", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    wait_edges(3);
    check_eq("glitch_state_stable", 32'(dbg_state), 32'(S_STABLE));
    wait_edges(4);           // now in the 5th STABLE cycle
    pll_locked = 1'b0;
    wait_edges(2);
    pll_locked = 1'b1;
    wait_edges(1);
    check_eq("glitch_state_back_wait", 32'(dbg_state), 32'(S_WAIT_LOCK));
    check_eq("glitch_sys_rst_n_held", 32'(sys_rst_n), 32'd0);
    wait_edges(9);
    check_eq("glitch_sys_rst_n_pre", 32'(sys_rst_n), 32'd0);
    wait_edges(1);
    check_eq("glitch_sys_rst_n", 32'(sys_rst_n), 32'd1);
    check_eq("glitch_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check_eq("glitch_retry_cnt", 32'(retry_cnt), 32'd0);

    // ---- timeout (watchdog) or indefinite wait ----
    pll_locked = 1'b0;
    wait_edges(3);
    exp_loss = 1;
    check_eq("to_loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss));
    wait_edges(4);
    check_eq("to_enter_wait", 32'(dbg_state), 32'(S_WAIT_LOCK));
`ifdef PLL_RESET_CTRL_WATCHDOG_EN
    for (int k = 1; k <= 3; k++) begin
      wait_edges(31);
      check_eq($sformatf("to_pll_rst_low_%0d", k), 32'(pll_rst), 32'd0);
      wait_edges(1);
      check_eq($sformatf("to_pll_rst_high_%0d", k), 32'(pll_rst), 32'd1);
      check_eq($sformatf("to_retry_cnt_%0d", k), 32'(retry_cnt), 32'(k));
      wait_edges(4);
      check_eq($sformatf("to_pll_rst_end_%0d", k), 32'(pll_rst), 32'd0);
    end
    // Priority: the synchronized lock arrives exactly on the timeout edge.
    wait_edges(29);
    pll_locked = 1'b1;
    wait_edges(3);
    check_eq("prio_state_stable", 32'(dbg_state), 32'(S_STABLE));
    check_eq("prio_pll_rst", 32'(pll_rst), 32'd0);
    check_eq("prio_retry_cnt", 32'(retry_cnt), 32'd3);
    wait_edges(7);
    check_eq("prio_sys_rst_n_pre", 32'(sys_rst_n), 32'd0);
    wait_edges(1);
    check_eq("prio_sys_rst_n", 32'(sys_rst_n), 32'd1);
`else
    for (int i = 0; i < 1000; i++) begin
      wait_edges(1);
      if (pll_rst) seen_rst = 1'b1;
    end
    check_eq("nowd_no_repulse", 32'(seen_rst), 32'd0);
    check_eq("nowd_retry_cnt", 32'(retry_cnt), 32'd0);
    check_eq("nowd_state_wait", 32'(dbg_state), 32'(S_WAIT_LOCK));
    pll_locked = 1'b1;
    expect_release("nowd_relock");
`endif

    // ---- lock-loss counter saturation ----
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      wait_edges(3);
      if (exp_loss < 255) exp_loss++;
      check_eq($sformatf("sat_loss_cnt_%0d", i), 32'(lock_loss_cnt), 32'(exp_loss));
      pll_locked = 1'b1;
      wait_edges(13);
    end
    check_eq("sat_loss_cnt_final", 32'(lock_loss_cnt), 32'd255);
    check_eq("sat_sys_rst_n", 32'(sys_rst_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer and lock supervisor for the system PLL, running on the PLL's 50 MHz reference clock. It drives the PLL's active-high reset and consumes its asynchronous `locked` output. It releases the design-wide reset only after lock has been continuously stable. It also re-arms the PLL on lock loss or lock timeout and counts those events for debug.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: refclk cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: max refclk cycles in WAIT_LOCK before re-pulsing the PLL (≥1).
- `CNT_W`, 16: width of the shared cycle counter; must hold max(parameters)−1.

Ports:
- `refclk`, input, 1: the block's single clock, 50 MHz board reference.
- `rst_n`, input, 1: asynchronous, active-low reset; one clock domain.
- `pll_locked`, input, 1: PLL lock, asynchronous to `refclk`.
- `pll_rst`, output, 1: PLL reset, active high.
- `sys_rst_n`, output, 1: design reset, active low; high only in RUN.
- `ready`, output, 1: equals `sys_rst_n`; status LED/CSR.
- `lock_loss_cnt`, output, 8: count of RUN→lock-lost events; saturates at 255.
- `retry_cnt`, output, 8: count of lock timeouts; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer, producing `locked_s`. No other logic samples `pll_locked` directly.
- FSM states: RESET_PLL, WAIT_LOCK, STABLE, RUN. The cycle counter clears on every state change.
- RESET_PLL: counts to `RST_PULSE_CYCLES`−1, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - `locked_s`=1: go to STABLE.
  - Otherwise, when the counter reaches `LOCK_TIMEOUT_CYCLES`−1: go to RESET_PLL and increment `retry_cnt`.
- STABLE:
  - `locked_s`=0: go to WAIT_LOCK. This is the glitch filter; the timeout window restarts.
  - Otherwise, when the counter reaches `LOCK_STABLE_CYCLES`−1: go to RUN.
- RUN: `locked_s`=0 sends the FSM to RESET_PLL and increments `lock_loss_cnt`. No filtering is applied on loss.
- Outputs are registered state decodes that update on the same edge as the state register:
  - `pll_rst` = (state==RESET_PLL).
  - `sys_rst_n` = `ready` = (state==RUN).
- Both event counters saturate at 255. Neither wraps.
- Async reset state, applied immediately with no clock required:
  - FSM in RESET_PLL, cycle counter 0, synchronizer 0.
  - `pll_rst`=1, `sys_rst_n`=0, `ready`=0.
  - `lock_loss_cnt`=0, `retry_cnt`=0.
- Reset mid-operation aborts any state, including RUN, and restarts the full sequence.
- Simultaneous events: in WAIT_LOCK, if `locked_s` rises on the timeout cycle, the lock takes priority. The FSM goes to STABLE and `retry_cnt` is unchanged.

## Timing
- After `rst_n` deassertion, `pll_rst` stays high for exactly `RST_PULSE_CYCLES` rising edges.
- Lock acquire: sampling latency is 2 edges. From the first edge sampling `pll_locked`=1 while in WAIT_LOCK, `sys_rst_n` rises at edge `LOCK_STABLE_CYCLES`+3, provided lock is held.
- Lock loss: from the first edge sampling `pll_locked`=0 in RUN:
  - `sys_rst_n` falls and `pll_rst` rises on edge 3.
  - `lock_loss_cnt` updates on that same edge.
- Timeout: `pll_rst` re-asserts `LOCK_TIMEOUT_CYCLES` edges after WAIT_LOCK entry.
- `pll_locked` pulses shorter than one refclk period may be missed. This is acceptable.

## Configuration
- `PLL_RESET_CTRL_WATCHDOG_EN` defined:
  - The WAIT_LOCK timeout and `retry_cnt` increment are compiled in.
- Not defined:
  - WAIT_LOCK waits indefinitely for lock.
  - `retry_cnt` is tied to 0.
  - `LOCK_TIMEOUT_CYCLES` is ignored.
  - All other behaviour is identical.

## Test plan
Bench parameters: `RST_PULSE_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, watchdog enabled unless noted.
- Clean bring-up: release `rst_n`; raise `pll_locked` 10 cycles after `pll_rst` falls → `pll_rst` high 4 cycles; `sys_rst_n`/`ready` rise exactly 11 edges after `pll_locked` first sampled high; both counters 0.
- Glitch in STABLE: drop `pll_locked` for 2 cycles at the 5th STABLE cycle → no release; `sys_rst_n` rises 11 edges after lock returns; counters 0.
- Lock loss in RUN: drop `pll_locked` → on edge 3, `sys_rst_n`=0, `pll_rst`=1, `lock_loss_cnt`=1; relock → normal release.
- Timeout: hold `pll_locked`=0 → `pll_rst` re-pulses every 4+32 cycles; `retry_cnt` = 1, 2, 3…. Repeat with the macro undefined → no re-pulse over 1000 cycles; `retry_cnt`=0.
- Saturation and priority:
  - Force 260 lock losses → `lock_loss_cnt`=255.
  - Raise lock on the timeout cycle → STABLE entered; `retry_cnt` unchanged.
- Async reset in RUN: assert `rst_n` between clock edges → `sys_rst_n`=0, `pll_rst`=1, counters 0 before the next edge.
